axi_rd_lat_slave: RTL and testbench
===================================

# axi_rd_lat_slave

Synthesizable AXI4 read-only slave that stands in for DDR downstream of the memory agent's read master (`M_AXI_AR*`/`M_AXI_R*` side). It accepts read-address requests, holds each for a fixed `RD_LATENCY`, and returns full bursts of address-derived data in request order. It replaces the ad-hoc shift-register responder in agent benches and runs on-board as a deterministic traffic sink. It adds burst length, RLAST, RID echo, backpressure and error responses.

## Interface
- `ID_W`, 1, AXI ID width
- `ADDR_W`, 32, address width
- `DATA_W`, 64, read data width; power of 2, ≥ 8
- `RD_LATENCY`, 10, AR-handshake-to-pipeline-exit delay in cycles; ≥ 1
- `AR_DEPTH`, 4, max outstanding bursts; power of 2, ≥ 1

Ports:
- `ACLK` in 1: clock, rising edge
- `ARESETN` in 1: reset, asynchronous, active-low
- `S_AXI_ARID` in ID_W: request ID
- `S_AXI_ARADDR` in ADDR_W: start address
- `S_AXI_ARLEN` in 8: beats − 1
- `S_AXI_ARSIZE` in 3: log2 bytes per beat
- `S_AXI_ARBURST` in 2: 00 FIXED, 01 INCR, 10 WRAP
- `S_AXI_ARVALID` in 1 / `S_AXI_ARREADY` out 1: address handshake
- `S_AXI_RID` out ID_W: echoed ARID
- `S_AXI_RDATA` out DATA_W: beat address, zero-extended or truncated to DATA_W
- `S_AXI_RRESP` out 2: 00 OKAY, 10 SLVERR
- `S_AXI_RLAST` out 1: final beat of burst
- `S_AXI_RVALID` out 1 / `S_AXI_RREADY` in 1: data handshake
- `outstanding_out` out $clog2(AR_DEPTH+1): bursts accepted but not completed
- `err_out` out 1: sticky; set on any SLVERR burst, cleared only by reset

## Operation
- Occupancy counter `occ` counts entries in the delay line, the command FIFO and the active burst.
- `ARREADY = ARESETN && (occ < AR_DEPTH)`. It is driven from registered state only and does not depend on ARVALID or RREADY.
- AR handshake: {ID, addr, len, size, burst} enters a RD_LATENCY-stage delay line (valid + payload), and `occ` increments.
- On delay-line exit the entry is pushed into an AR_DEPTH-entry command FIFO. It cannot overflow because of `occ`.
- Burst engine FSM:
  - IDLE: if the FIFO is non-empty, pop the head, load beat_addr = ARADDR and beat_cnt = ARLEN, compute the error flag, go to BURST with RVALID = 1.
  - BURST: on R handshake, if beat_cnt == 0 the burst completes (see below). Otherwise decrement beat_cnt and advance beat_addr.
  - Burst completion: `occ` decrements. If the FIFO is non-empty, pop the next head and present its first beat on the next cycle with no bubble. Otherwise go to IDLE with RVALID = 0.
- Address advance:
  - INCR: beat_addr += 1 << ARSIZE, modulo 2^ADDR_W. There is no 4 KB check.
  - FIXED: beat_addr is unchanged.
- Error: ARBURST ∈ {WRAP, 11} or (1 << ARSIZE) > DATA_W/8 gives RRESP = SLVERR on every beat of that burst and sets `err_out`. Data is generated as INCR for WRAP/11, and ARSIZE is used as given.
- RLAST = 1 exactly when beat_cnt == 0 while in BURST.
- AR accept and burst completion in the same cycle: `occ` is unchanged (+1 −1).
- `outstanding_out = occ`.

## Timing
- Reset (asynchronous assert, released synchronously to ACLK by the system) clears the delay line, FIFO, FSM, `occ` and `err_out` immediately.
- Reset values of outputs:
  - ARREADY, RVALID, RLAST, `err_out`: 0
  - RID, RDATA, RRESP: 0
  - `outstanding_out`: 0
- ARREADY is 1 in the first cycle after ARESETN rises.
- Minimum latency: AR handshake at edge N gives first RVALID high after edge N + RD_LATENCY + 1 when the engine is idle and the FIFO is empty.
- Throughput: one beat per cycle with RREADY held high; bursts run back-to-back.
- While RVALID = 1 and RREADY = 0, RID/RDATA/RRESP/RLAST hold stable and RVALID stays high.
- Freed capacity becomes visible: completion at edge M raises ARREADY after edge M.
- Bursts are returned strictly in AR order, regardless of ID.

## Test plan
- Single beat: ARADDR = 0x100, ARLEN = 0, INCR, ARSIZE = 3, handshake at edge N, RREADY = 1 → RVALID after edge N+11 (RD_LATENCY = 10), RDATA = 0x100, RLAST = 1, RRESP = 0, RID echoed, `outstanding_out` returns to 0.
- INCR burst: ARADDR = 0x1000, ARLEN = 3, ARSIZE = 3 → RDATA 0x1000, 0x1008, 0x1010, 0x1018 on consecutive cycles, RLAST only on the 4th. FIXED, same request → four beats of 0x1000.
- Backpressure: ARVALID held high, RREADY = 0 → exactly 4 handshakes, ARREADY low, `outstanding_out` = 4. Release RREADY → ARREADY high the cycle after the first burst's RLAST handshake, and bursts return in order with no inter-burst bubble.
- RREADY toggling 1/0 every cycle during ARLEN = 7 → each beat held stable while stalled, 8 beats total, no beat lost or duplicated.
- Errors: ARBURST = WRAP, ARLEN = 1 → 2 beats with RRESP = 10 and `err_out` = 1 afterward. ARSIZE = 4 with DATA_W = 64 → SLVERR. A following valid request → OKAY, `err_out` remains 1.
- Reset mid-burst (beat 2 of 4): all outputs go to reset values without waiting for an edge. The next request after release returns its own full burst at the normal latency, with no residue from the aborted burst.

Source files
------------

// File: rtl/axi_rd_lat_slave_if.sv
// AXI4 read-channel bundle (AR + R) between a read master and axi_rd_lat_slave.
interface axi_rd_lat_slave_if #(
  parameter int unsigned ID_W   = 1,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic [ID_W-1:0]   S_AXI_ARID;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic [7:0]        S_AXI_ARLEN;
  logic [2:0]        S_AXI_ARSIZE;
  logic [1:0]        S_AXI_ARBURST;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [ID_W-1:0]   S_AXI_RID;
  logic [DATA_W-1:0] S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RLAST;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport slave (
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_rd_lat_slave.sv
// AXI4 read-only slave: fixed-latency delay line, in-order command FIFO and a
// burst engine returning the beat address as read data.
module axi_rd_lat_slave #(
  parameter int unsigned ID_W       = 1,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned RD_LATENCY = 10,
  parameter int unsigned AR_DEPTH   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  axi_rd_lat_slave_if.slave              s_axi,
  output logic [$clog2(AR_DEPTH+1)-1:0]  outstanding_out,
  output logic                           err_out
);

  localparam int unsigned OCC_W     = $clog2(AR_DEPTH + 1);
  localparam int unsigned PTR_W     = (AR_DEPTH > 1) ? $clog2(AR_DEPTH) : 1;
  localparam int unsigned MAX_SIZE  = $clog2(DATA_W / 8);
  localparam int unsigned BURST_LSB = 0;
  localparam int unsigned SIZE_LSB  = 2;
  localparam int unsigned LEN_LSB   = 5;
  localparam int unsigned ADDR_LSB  = 13;
  localparam int unsigned ID_LSB    = ADDR_LSB + ADDR_W;
  localparam int unsigned CMD_W     = ID_LSB + ID_W;

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(AR_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic              arready_c;
  logic              ar_hs_c;
  logic [CMD_W-1:0]  ar_cmd_c;

  logic [RD_LATENCY-1:0] dl_vld_q;
  logic [CMD_W-1:0]      dl_cmd_q [RD_LATENCY];

  logic [CMD_W-1:0]  fifo_q [AR_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]  fifo_cnt_q;
  logic              push_c, pop_c, done_c, load_c;

  logic [CMD_W-1:0]  head_c;
  logic              head_err_c;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] beat_addr_q, beat_addr_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  // Capacity gate depends only on registered occupancy and reset.
  assign arready_c = ARESETN && (occ_q < OCC_W'(AR_DEPTH));
  assign ar_hs_c   = s_axi.S_AXI_ARVALID && arready_c;
  assign ar_cmd_c  = {s_axi.S_AXI_ARID, s_axi.S_AXI_ARADDR, s_axi.S_AXI_ARLEN,
                      s_axi.S_AXI_ARSIZE, s_axi.S_AXI_ARBURST};

  // Fixed-latency delay line; every stage shifts each cycle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      dl_vld_q <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) dl_cmd_q[i] <= '0;
    end else begin
      dl_vld_q[0] <= ar_hs_c;
      dl_cmd_q[0] <= ar_cmd_c;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_cmd_q[i] <= dl_cmd_q[i-1];
      end
    end
  end

  assign push_c = dl_vld_q[RD_LATENCY-1];

  // Command FIFO; occupancy limit guarantees it never overflows.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < int'(AR_DEPTH); i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push_c) begin
        fifo_q[wr_ptr_q] <= dl_cmd_q[RD_LATENCY-1];
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_q + OCC_W'(push_c) - OCC_W'(pop_c);
    end
  end

  assign head_c     = fifo_q[rd_ptr_q];
  assign head_err_c = head_c[BURST_LSB+1] || (head_c[SIZE_LSB +: 3] > 3'(MAX_SIZE));

  // Burst engine next-state and R-channel output logic.
  always_comb begin
    state_d     = state_q;
    beat_addr_d = beat_addr_q;
    beat_cnt_d  = beat_cnt_q;
    size_d      = size_q;
    burst_d     = burst_q;
    rid_d       = rid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    rvalid_d    = rvalid_q;
    err_d       = err_q;
    load_c      = 1'b0;
    done_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fifo_cnt_q != '0) load_c = 1'b1;
      end
      ST_BURST: begin
        if (s_axi.S_AXI_RREADY) begin
          if (beat_cnt_q == 8'd0) begin
            done_c = 1'b1;
            if (fifo_cnt_q != '0) begin
              load_c = 1'b1;
            end else begin
              state_d  = ST_IDLE;
              rvalid_d = 1'b0;
              rlast_d  = 1'b0;
            end
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
            if (burst_q != 2'b00) beat_addr_d = beat_addr_q + (ADDR_W'(1) << size_q);
            rdata_d = DATA_W'(beat_addr_d);
            rlast_d = (beat_cnt_d == 8'd0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Back-to-back load: next burst's first beat appears without a bubble.
    if (load_c) begin
      state_d     = ST_BURST;
      beat_addr_d = head_c[ADDR_LSB +: ADDR_W];
      beat_cnt_d  = head_c[LEN_LSB +: 8];
      size_d      = head_c[SIZE_LSB +: 3];
      burst_d     = head_c[BURST_LSB +: 2];
      rid_d       = head_c[ID_LSB +: ID_W];
      rdata_d     = DATA_W'(head_c[ADDR_LSB +: ADDR_W]);
      rresp_d     = head_err_c ? 2'b10 : 2'b00;
      rlast_d     = (head_c[LEN_LSB +: 8] == 8'd0);
      rvalid_d    = 1'b1;
      if (head_err_c) err_d = 1'b1;
    end
  end

  assign pop_c = load_c;
  assign occ_d = occ_q + OCC_W'(ar_hs_c) - OCC_W'(done_c);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      beat_addr_q <= '0;
      beat_cnt_q  <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      rid_q       <= '0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      rlast_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_addr_q <= beat_addr_d;
      beat_cnt_q  <= beat_cnt_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      rid_q       <= rid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rlast_q     <= rlast_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      occ_q       <= occ_d;
    end
  end

  assign s_axi.S_AXI_ARREADY = arready_c;
  assign s_axi.S_AXI_RID     = rid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RLAST   = rlast_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign outstanding_out     = occ_q;
  assign err_out             = err_q;

endmodule

// File: tb/tb_axi_rd_lat_slave.sv
// Self-checking bench for axi_rd_lat_slave: directed scenarios plus randomized
// traffic scored against a beat-list reference model.
module tb_axi_rd_lat_slave;

  localparam int unsigned LAT   = 10;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [0:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] outstanding;
  logic       err;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    model_occ = 0;
  int    ar_cnt = 0;
  int    beat_cnt = 0;
  beat_t exp_q[$];

  axi_rd_lat_slave_if #(.ID_W(1), .ADDR_W(32), .DATA_W(64)) bus ();

  axi_rd_lat_slave #(
    .ID_W(1), .ADDR_W(32), .DATA_W(64), .RD_LATENCY(LAT), .AR_DEPTH(DEPTH)
  ) dut (
    .ACLK(clk),
    .ARESETN(rst_n),
    .s_axi(bus),
    .outstanding_out(outstanding),
    .err_out(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: each accepted request expands into its full beat list.
  always @(negedge clk) begin
    beat_t       b;
    logic [31:0] a;
    bit          e;
    if (rst_n) begin
      chk("outstanding", 64'(outstanding), 64'(model_occ));
      chk("arready", 64'(bus.S_AXI_ARREADY), 64'(model_occ < int'(DEPTH)));
      if (bus.S_AXI_RVALID) begin
        chk("r_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          b = exp_q[0];
          chk("rid", 64'(bus.S_AXI_RID), 64'(b.id));
          chk("rdata", bus.S_AXI_RDATA, b.data);
          chk("rresp", 64'(bus.S_AXI_RRESP), 64'(b.resp));
          chk("rlast", 64'(bus.S_AXI_RLAST), 64'(b.last));
          if (bus.S_AXI_RREADY) begin
            void'(exp_q.pop_front());
            beat_cnt++;
            if (b.last) model_occ--;
          end
        end
      end
      if (bus.S_AXI_ARVALID && bus.S_AXI_ARREADY) begin
        e = bus.S_AXI_ARBURST[1] || ((32'd1 << bus.S_AXI_ARSIZE) > 32'd8);
        for (int i = 0; i <= int'(bus.S_AXI_ARLEN); i++) begin
          a = bus.S_AXI_ARADDR;
          if (bus.S_AXI_ARBURST != 2'b00) a = a + (32'(i) << bus.S_AXI_ARSIZE);
          b.id   = bus.S_AXI_ARID;
          b.data = {32'd0, a};
          b.resp = e ? 2'b10 : 2'b00;
          b.last = (i == int'(bus.S_AXI_ARLEN));
          exp_q.push_back(b);
        end
        model_occ++;
        ar_cnt++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_ar(input logic id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    bus.S_AXI_ARID    = id;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARLEN   = len;
    bus.S_AXI_ARSIZE  = size;
    bus.S_AXI_ARBURST = burst;
  endtask

  // Holds ARVALID until accepted; returns the edge number of the handshake.
  task automatic send_ar(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input bit rnd_rdy, output int n);
    bit hs = 1'b0;
    int k = 0;
    set_ar(id, addr, len, size, burst);
    bus.S_AXI_ARVALID = 1'b1;
    while (!hs && k < 200) begin
      @(negedge clk);
      hs = bus.S_AXI_ARREADY;
      @(posedge clk); #1;
      k++;
      if (rnd_rdy) bus.S_AXI_RREADY = 1'($urandom_range(0, 1));
    end
    bus.S_AXI_ARVALID = 1'b0;
    n = cyc;
    chk("ar_accept", 64'(hs), 64'd1);
  endtask

  // Leaves the caller at the negedge where RVALID is first seen high.
  task automatic wait_rvalid(input string tag, output int m);
    int k = 0;
    do begin @(negedge clk); k++; end while (!bus.S_AXI_RVALID && k < 100);
    m = cyc;
    chk(tag, 64'(bus.S_AXI_RVALID), 64'd1);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    bus.S_AXI_RREADY = 1'b1;
    while ((exp_q.size() != 0 || model_occ != 0) && k < 3000) begin
      @(posedge clk); #1; k++;
    end
    cycles(2);
    chk(tag, 64'(outstanding), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, a0, b0, cnt;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;
    set_ar(1'b0, 32'd0, 8'd0, 3'd0, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_arready", 64'(bus.S_AXI_ARREADY), 64'd0);
    chk("rst_rvalid", 64'(bus.S_AXI_RVALID), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("arready_after_reset", 64'(bus.S_AXI_ARREADY), 64'd1);

    // Single beat with minimum latency.
    bus.S_AXI_RREADY = 1'b1;
    send_ar(1'b1, 32'h100, 8'd0, 3'd3, 2'b01, 1'b0, n);
    wait_rvalid("single_rvalid", m);
    chk("single_latency", 64'(m), 64'(n + int'(LAT) + 1));
    chk("single_rdata", bus.S_AXI_RDATA, 64'h100);
    chk("single_rlast", 64'(bus.S_AXI_RLAST), 64'd1);
    chk("single_rid", 64'(bus.S_AXI_RID), 64'd1);
    @(posedge clk); #1;
    cycles(2);
    chk("single_outstanding", 64'(outstanding), 64'd0);

    // INCR then FIXED bursts of four beats.
    for (int f = 0; f < 2; f++) begin
      send_ar(1'b0, 32'h1000, 8'd3, 3'd3, (f == 0) ? 2'b01 : 2'b00, 1'b0, n);
      wait_rvalid("burst_rvalid", m);
      for (int i = 0; i < 4; i++) begin
        chk("burst_rdata", bus.S_AXI_RDATA, (f == 0) ? 64'h1000 + 64'(8 * i) : 64'h1000);
        chk("burst_rlast", 64'(bus.S_AXI_RLAST), 64'(i == 3));
        @(negedge clk);
      end
      chk("burst_end_rvalid", 64'(bus.S_AXI_RVALID), 64'd0);
      @(posedge clk); #1;
    end

    // Backpressure fills all slots, then drains back-to-back.
    bus.S_AXI_RREADY = 1'b0;
    a0 = ar_cnt;
    set_ar(1'b1, 32'h2000, 8'd3, 3'd3, 2'b01);
    bus.S_AXI_ARVALID = 1'b1;
    cycles(30);
    bus.S_AXI_ARVALID = 1'b0;
    chk("bp_handshakes", 64'(ar_cnt - a0), 64'd4);
    chk("bp_arready", 64'(bus.S_AXI_ARREADY), 64'd0);
    chk("bp_outstanding", 64'(outstanding), 64'd4);
    bus.S_AXI_RREADY = 1'b1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.S_AXI_RVALID) cnt++;
    end
    chk("bp_no_bubble", 64'(cnt), 64'd16);
    @(negedge clk);
    chk("bp_end_rvalid", 64'(bus.S_AXI_RVALID), 64'd0);
    @(posedge clk); #1;

    // RREADY toggling each cycle over an 8-beat burst.
    b0 = beat_cnt;
    send_ar(1'b0, 32'h3000, 8'd7, 3'd3, 2'b01, 1'b0, n);
    for (int i = 0; i < 60; i++) begin
      bus.S_AXI_RREADY = ~bus.S_AXI_RREADY;
      @(posedge clk); #1;
    end
    drain("toggle_outstanding");
    chk("toggle_beats", 64'(beat_cnt - b0), 64'd8);

    // Error responses and sticky err_out.
    send_ar(1'b1, 32'h40, 8'd1, 3'd3, 2'b10, 1'b0, n);
    wait_rvalid("wrap_rvalid", m);
    chk("wrap_rresp", 64'(bus.S_AXI_RRESP), 64'd2);
    @(posedge clk); #1;
    drain("wrap_outstanding");
    chk("wrap_err", 64'(err), 64'd1);
    send_ar(1'b0, 32'h80, 8'd0, 3'd4, 2'b01, 1'b0, n);
    wait_rvalid("size_rvalid", m);
    chk("size_rresp", 64'(bus.S_AXI_RRESP), 64'd2);
    @(posedge clk); #1;
    send_ar(1'b0, 32'h90, 8'd0, 3'd2, 2'b01, 1'b0, n);
    wait_rvalid("ok_rvalid", m);
    chk("ok_rresp", 64'(bus.S_AXI_RRESP), 64'd0);
    chk("ok_err_sticky", 64'(err), 64'd1);
    @(posedge clk); #1;
    drain("err_outstanding");

    // Randomized traffic with random RREADY.
    for (int r = 0; r < 40; r++) begin
      send_ar(1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 7)),
              3'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), 1'b1, n);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        bus.S_AXI_RREADY = 1'($urandom_range(0, 1));
      end
    end
    drain("rand_outstanding");
    chk("rand_model_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset in the middle of a burst.
    send_ar(1'b1, 32'h4000, 8'd3, 3'd3, 2'b01, 1'b0, n);
    wait_rvalid("abort_rvalid", m);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rvalid_low", 64'(bus.S_AXI_RVALID), 64'd0);
    chk("abort_rlast", 64'(bus.S_AXI_RLAST), 64'd0);
    chk("abort_rdata", bus.S_AXI_RDATA, 64'd0);
    chk("abort_rid", 64'(bus.S_AXI_RID), 64'd0);
    chk("abort_rresp", 64'(bus.S_AXI_RRESP), 64'd0);
    chk("abort_arready", 64'(bus.S_AXI_ARREADY), 64'd0);
    chk("abort_outstanding", 64'(outstanding), 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    exp_q.delete();
    model_occ = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("abort_arready_release", 64'(bus.S_AXI_ARREADY), 64'd1);
    send_ar(1'b0, 32'h5000, 8'd3, 3'd3, 2'b01, 1'b0, n);
    wait_rvalid("post_rvalid", m);
    chk("post_latency", 64'(m), 64'(n + int'(LAT) + 1));
    for (int i = 0; i < 4; i++) begin
      chk("post_rdata", bus.S_AXI_RDATA, 64'h5000 + 64'(8 * i));
      chk("post_rid", 64'(bus.S_AXI_RID), 64'd0);
      @(negedge clk);
    end
    chk("post_end_rvalid", 64'(bus.S_AXI_RVALID), 64'd0);
    @(posedge clk); #1;
    drain("post_outstanding");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
